// File: rtl/switch_allocator_rr_if.sv
// Allocator handshake bundle: route/flit/credit status in, grants and crossbar selects out.
interface switch_allocator_rr_if #(
   parameter int unsigned N = 5,
   parameter int unsigned M = 3
);
   logic [0:N-1]               i_select_neighbor;
   logic [0:N-1][0:M-1][1:0]   i_avail_directions;
   logic [0:N-1]               i_local;
   logic [0:N-1]               i_flit_valid;
   logic [0:N-1]               i_flit_tail;
   logic [0:N-1]               i_credit_avail;
   logic [0:N-1]               o_grant;
   logic [0:N-1]               o_xbar_valid;
   logic [0:N-1][2:0]          o_xbar_sel;
   logic [0:N-1]               o_in_busy;

   modport master (
      output i_select_neighbor, i_avail_directions, i_local, i_flit_valid, i_flit_tail,
             i_credit_avail,
      input  o_grant, o_xbar_valid, o_xbar_sel, o_in_busy
   );

   modport slave (
      input  i_select_neighbor, i_avail_directions, i_local, i_flit_valid, i_flit_tail,
             i_credit_avail,
      output o_grant, o_xbar_valid, o_xbar_sel, o_in_busy
   );
endinterface

// File: rtl/switch_allocator_rr.sv
// Router switch allocator: per-input ordered candidate choice, per-output round-robin
// arbitration, and output locking from head flit to tail flit.
module switch_allocator_rr #(
   parameter int unsigned N = 5,
   parameter int unsigned M = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   switch_allocator_rr_if.slave   io_alloc
);
   localparam int unsigned NC = M - 1;

   typedef enum logic [1:0] {StIdle, StRouted, StActive} state_e;

   state_e       r_state [N];
   logic [2:0]   r_cand  [N][NC];
   logic [1:0]   r_cnt   [N];
   logic [2:0]   r_own   [N];
   logic [0:N-1] r_lock;
   logic [2:0]   r_owner [N];
   logic [2:0]   r_rr    [N];

   state_e       w_state_nxt [N];
   logic [2:0]   w_cand_nxt  [N][NC];
   logic [1:0]   w_cnt_nxt   [N];
   logic [2:0]   w_own_nxt   [N];
   logic [0:N-1] w_lock_nxt;
   logic [2:0]   w_owner_nxt [N];
   logic [2:0]   w_rr_nxt    [N];

   logic [0:N-1] w_req_vld;
   logic [2:0]   w_req_port  [N];
   logic [0:N-1] w_win;
   logic [2:0]   w_win_idx   [N];
   logic [0:N-1] w_won;
   logic [2:0]   w_won_port  [N];
   logic [0:N-1] w_grant;

   always_comb begin : p_alloc
      int idx;
      idx = 0;
      // Each routed input requests only its first free, credited candidate.
      for (int i = 0; i < N; i++) begin
         w_req_vld[i]  = 1'b0;
         w_req_port[i] = 3'd0;
         if (r_state[i] == StRouted) begin
            for (int k = 0; k < NC; k++) begin
               if (!w_req_vld[i] && k < int'(r_cnt[i]) && !r_lock[r_cand[i][k]] &&
                   io_alloc.i_credit_avail[r_cand[i][k]]) begin
                  w_req_vld[i]  = 1'b1;
                  w_req_port[i] = r_cand[i][k];
               end
            end
         end
      end

      for (int o = 0; o < N; o++) begin
         w_win[o]     = 1'b0;
         w_win_idx[o] = 3'd0;
         if (!r_lock[o]) begin
            for (int off = 0; off < N; off++) begin
               idx = int'(r_rr[o]) + off;
               if (idx >= int'(N)) idx = idx - int'(N);
               if (!w_win[o] && w_req_vld[idx] && w_req_port[idx] == 3'(o)) begin
                  w_win[o]     = 1'b1;
                  w_win_idx[o] = 3'(idx);
               end
            end
         end
      end

      w_won = '0;
      for (int i = 0; i < N; i++) w_won_port[i] = 3'd0;
      for (int o = 0; o < N; o++) begin
         if (w_win[o]) begin
            w_won[w_win_idx[o]]      = 1'b1;
            w_won_port[w_win_idx[o]] = 3'(o);
         end
      end

      for (int i = 0; i < N; i++) begin
         w_grant[i] = (r_state[i] == StActive) && io_alloc.i_flit_valid[i] &&
                      io_alloc.i_credit_avail[r_own[i]];
      end

      for (int i = 0; i < N; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cand_nxt[i]  = r_cand[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_own_nxt[i]   = r_own[i];
         unique case (r_state[i])
            StIdle: begin
               if (io_alloc.i_select_neighbor[i]) begin
                  w_state_nxt[i] = StRouted;
                  // An empty list is delivered locally, same as an explicit local flag.
                  if (io_alloc.i_local[i] || io_alloc.i_avail_directions[i][M-1] == 2'd0) begin
                     w_cand_nxt[i][0] = 3'd0;
                     w_cnt_nxt[i]     = 2'd1;
                  end else begin
                     for (int k = 0; k < NC; k++) begin
                        w_cand_nxt[i][k] = 3'(io_alloc.i_avail_directions[i][k]) + 3'd1;
                     end
                     w_cnt_nxt[i] = (io_alloc.i_avail_directions[i][M-1] > 2'(NC)) ?
                                    2'(NC) : io_alloc.i_avail_directions[i][M-1];
                  end
               end
            end
            StRouted: begin
               if (w_won[i]) begin
                  w_state_nxt[i] = StActive;
                  w_own_nxt[i]   = w_won_port[i];
               end
            end
            StActive: begin
               if (w_grant[i] && io_alloc.i_flit_tail[i]) w_state_nxt[i] = StIdle;
            end
            default: w_state_nxt[i] = StIdle;
         endcase
      end

      for (int o = 0; o < N; o++) begin
         w_lock_nxt[o]  = r_lock[o];
         w_owner_nxt[o] = r_owner[o];
         w_rr_nxt[o]    = r_rr[o];
         if (w_win[o]) begin
            w_lock_nxt[o]  = 1'b1;
            w_owner_nxt[o] = w_win_idx[o];
            w_rr_nxt[o]    = (w_win_idx[o] == 3'(N - 1)) ? 3'd0 : w_win_idx[o] + 3'd1;
         end else if (r_lock[o] && w_grant[r_owner[o]] && io_alloc.i_flit_tail[r_owner[o]]) begin
            w_lock_nxt[o]  = 1'b0;
            w_owner_nxt[o] = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            r_state[i] <= StIdle;
            r_cnt[i]   <= 2'd0;
            r_own[i]   <= 3'd0;
            r_owner[i] <= 3'd0;
            r_rr[i]    <= 3'd0;
            for (int k = 0; k < NC; k++) r_cand[i][k] <= 3'd0;
         end
         r_lock <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_cnt   <= w_cnt_nxt;
         r_own   <= w_own_nxt;
         r_lock  <= w_lock_nxt;
         r_owner <= w_owner_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   always_comb begin
      io_alloc.o_grant      = w_grant;
      io_alloc.o_xbar_valid = '0;
      io_alloc.o_xbar_sel   = '0;
      io_alloc.o_in_busy    = '0;
      for (int o = 0; o < N; o++) begin
         io_alloc.o_xbar_valid[o] = r_lock[o] & w_grant[r_owner[o]];
         io_alloc.o_xbar_sel[o]   = r_lock[o] ? r_owner[o] : 3'd0;
      end
      for (int i = 0; i < N; i++) io_alloc.o_in_busy[i] = (r_state[i] != StIdle);
   end
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Randomized bench for switch_allocator_rr against a packet-level allocation model.
module tb_switch_allocator_rr;
   localparam int N = 5;
   localparam int M = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   switch_allocator_rr_if #(.N(N), .M(M)) bus ();

   switch_allocator_rr #(.N(N), .M(M)) dut (
      .clk      (clk),
      .reset    (reset),
      .io_alloc (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 idle, 1 waiting for an output, 2 holding an output; owner -1 means free.
   int m_state [N];
   int m_cand  [N][M];
   int m_ncand [N];
   int m_own   [N];
   int m_owner [N];
   int m_rr    [N];
   int winners [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_state[i] = 0; m_ncand[i] = 0; m_own[i] = 0; m_owner[i] = -1; m_rr[i] = 0;
      end
   endtask

   task automatic drive(input int mode);
      for (int i = 0; i < N; i++) begin
         if (mode == 1) begin
            bus.i_select_neighbor[i] = (m_state[i] == 0) && (i == 0 || i == 3 || i == 4);
            bus.i_local[i] = 1'b0;
            bus.i_avail_directions[i][0] = 2'd1;
            bus.i_avail_directions[i][1] = 2'd0;
            bus.i_avail_directions[i][M-1] = 2'd1;
            bus.i_flit_valid[i] = 1'b1;
            bus.i_flit_tail[i] = 1'b1;
            bus.i_credit_avail[i] = 1'b1;
         end else begin
            bus.i_select_neighbor[i] = (m_state[i] == 0) && ($urandom_range(0, 2) == 0);
            bus.i_local[i] = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < M - 1; k++) bus.i_avail_directions[i][k] = 2'($urandom_range(0, 3));
            bus.i_avail_directions[i][M-1] = 2'($urandom_range(0, M - 1));
            bus.i_flit_valid[i] = ($urandom_range(0, 4) != 0);
            bus.i_flit_tail[i] = ($urandom_range(0, 2) == 0);
            bus.i_credit_avail[i] = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   task automatic compare();
      logic [0:N-1] e_grant, e_xv, e_busy;
      logic [0:N-1][2:0] e_sel;
      for (int i = 0; i < N; i++) begin
         e_grant[i] = (m_state[i] == 2) && bus.i_flit_valid[i] && bus.i_credit_avail[m_own[i]];
         e_busy[i] = (m_state[i] != 0);
      end
      for (int o = 0; o < N; o++) begin
         e_xv[o] = (m_owner[o] >= 0) && e_grant[m_owner[o]];
         e_sel[o] = (m_owner[o] >= 0) ? 3'(m_owner[o]) : 3'd0;
      end
      check("grant", 32'(bus.o_grant), 32'(e_grant));
      check("xbar_valid", 32'(bus.o_xbar_valid), 32'(e_xv));
      check("xbar_sel", 32'(bus.o_xbar_sel), 32'(e_sel));
      check("in_busy", 32'(bus.o_in_busy), 32'(e_busy));
   endtask

   task automatic model_step();
      int req [N];
      int win [N];
      int j, n;
      for (int i = 0; i < N; i++) begin
         req[i] = -1;
         if (m_state[i] == 1) begin
            for (int k = 0; k < m_ncand[i]; k++) begin
               if (req[i] < 0 && m_owner[m_cand[i][k]] < 0 && bus.i_credit_avail[m_cand[i][k]])
                  req[i] = m_cand[i][k];
            end
         end
      end
      for (int o = 0; o < N; o++) begin
         win[o] = -1;
         if (m_owner[o] < 0) begin
            for (int k = 0; k < N; k++) begin
               j = (m_rr[o] + k) % N;
               if (win[o] < 0 && req[j] == o) win[o] = j;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_state[i] == 0 && bus.i_select_neighbor[i]) begin
            m_state[i] = 1;
            n = int'(bus.i_avail_directions[i][M-1]);
            if (bus.i_local[i] || n == 0) begin
               m_cand[i][0] = 0;
               m_ncand[i] = 1;
            end else begin
               for (int k = 0; k < n; k++) m_cand[i][k] = int'(bus.i_avail_directions[i][k]) + 1;
               m_ncand[i] = n;
            end
         end else if (m_state[i] == 2 && bus.i_flit_valid[i] && bus.i_credit_avail[m_own[i]] &&
                      bus.i_flit_tail[i]) begin
            m_owner[m_own[i]] = -1;
            m_state[i] = 0;
         end
      end
      for (int o = 0; o < N; o++) begin
         if (win[o] >= 0) begin
            m_owner[o] = win[o];
            m_state[win[o]] = 2;
            m_own[win[o]] = o;
            m_rr[o] = (win[o] + 1) % N;
         end
      end
   endtask

   task automatic step(input int mode);
      @(negedge clk);
      drive(mode);
      if (reset) model_reset();
      #1;
      compare();
      if (mode == 1 && bus.o_xbar_valid[2]) winners.push_back(int'(bus.o_xbar_sel[2]));
      @(posedge clk);
      if (!reset) model_step();
   endtask

   task automatic run_contention();
      int exp_w [4];
      exp_w = '{0, 3, 4, 0};
      winners.delete();
      for (int c = 0; c < 40 && winners.size() < 4; c++) step(1);
      check("rr_winner_count", 32'(winners.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_winner%0d", k), (k < winners.size()) ? 32'(winners[k]) : 32'hffff,
               32'(exp_w[k]));
      end
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      step(0);
      step(0);
      #2 reset = 1'b0;
      run_contention();
      for (int c = 0; c < 1200; c++) step(0);
      reset = 1'b1;
      step(0);
      #2 reset = 1'b0;
      run_contention();
      for (int c = 0; c < 800; c++) step(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
